// File: rtl/noc_inject_arbiter_pkg.sv
// Shared NoC arbiter definitions: flit width, arbiter FSM states and the
// round-robin pointer advance helper.
package noc_inject_arbiter_pkg;

  localparam int NOC_DATA_WIDTH = 32;

  typedef enum logic {
    NOC_ARB_IDLE   = 1'b0,
    NOC_ARB_LOCKED = 1'b1
  } arb_state_e;

  // Pointer moves to the requester just after the one that finished a packet.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/noc_inject_arbiter_rr_picker.sv
// Combinational round-robin first-set finder: picks the first set request at
// or after ptr_i, wrapping cyclically, and returns it one-hot and as an index.
module noc_rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic found;

  always_comb begin
    // NOTE: every output gets a default before the search so no path through
    // the loops leaves a value unassigned, which would otherwise infer a latch.
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    // Upper pass covers ptr..N-1, lower pass wraps around to 0..ptr-1.
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i] && (i >= int'(ptr_i))) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i]) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IW'(i);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-level wormhole arbiter sharing one NoC router injection port among
// NUM_REQ local sources, with round-robin fairness and a registered flit slot.
module noc_inject_arbiter
  import noc_inject_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = NOC_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16,
  localparam int IW        = $clog2(NUM_REQ)
) (
  input  logic                          noc_clk,
  input  logic                          noc_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_flit,
  input  logic [NUM_REQ-1:0]            req_is_header,
  input  logic [NUM_REQ-1:0]            req_is_tail,
  output logic                          Noc_sender_valid,
  input  logic                          Noc_sender_ready,
  output logic [DATA_WIDTH-1:0]         Noc_sender_flit,
  input  logic                          Noc_sender_VCready,
  output logic                          Noc_sender_is_header,
  output logic                          Noc_sender_is_tail,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy,
  output logic                          err_proto,
  output logic [CNT_WIDTH-1:0]          pkt_count
);

  arb_state_e           state_q, state_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]        grant_id_q, grant_id_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] pkt_count_q;

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_flit_q;
  logic                  out_hdr_q;
  logic                  out_tail_q;

  logic                  slot_free;
  logic [NUM_REQ-1:0]    cand;
  logic [NUM_REQ-1:0]    pick_gnt;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any;
  logic [IW-1:0]         sel_idx;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_flit;
  logic                  sel_hdr;
  logic                  sel_tail;
  logic [DATA_WIDTH-1:0] flits [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign flits[g] = req_flit[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // The slot can take a new flit when empty or when it drains this cycle.
  assign slot_free = !out_valid_q || Noc_sender_ready;
  assign cand      = req_valid & req_is_header;

  noc_rr_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_picker (
    .req_i (cand),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign sel_idx  = (state_q == NOC_ARB_IDLE) ? pick_idx : grant_id_q;
  assign sel_flit = flits[sel_idx];
  assign sel_hdr  = req_is_header[sel_idx];
  assign sel_tail = req_is_tail[sel_idx];
  assign accept   = |(req_ready & req_valid);

  // State register, output slot and counters.
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state_q     <= NOC_ARB_IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      err_q       <= 1'b0;
      pkt_count_q <= '0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      out_hdr_q   <= 1'b0;
      out_tail_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here sample the
      // pre-edge values, so statement order inside this block is irrelevant.
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      err_q      <= err_d;
      if (out_valid_q && Noc_sender_ready && out_tail_q) begin
        pkt_count_q <= pkt_count_q + CNT_WIDTH'(1);
      end
      if (accept) begin
        out_valid_q <= 1'b1;
        out_flit_q  <= sel_flit;
        out_hdr_q   <= sel_hdr;
        out_tail_q  <= sel_tail;
      end else if (Noc_sender_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Next-state logic: lock on a multi-flit header, release on its tail.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    err_d      = err_q;
    unique case (state_q)
      NOC_ARB_IDLE: begin
        if (|(req_valid & ~req_is_header)) begin
          err_d = 1'b1;
        end
        if (accept) begin
          grant_id_d = pick_idx;
          if (sel_tail) begin
            rr_ptr_d = IW'(rr_next(int'(pick_idx), NUM_REQ));
          end else begin
            state_d = NOC_ARB_LOCKED;
          end
        end
      end
      NOC_ARB_LOCKED: begin
        if (accept && sel_hdr) begin
          err_d = 1'b1;
        end
        if (accept && sel_tail) begin
          state_d  = NOC_ARB_IDLE;
          rr_ptr_d = IW'(rr_next(int'(grant_id_q), NUM_REQ));
        end
      end
      default: state_d = NOC_ARB_IDLE;
    endcase
  end

  // Output logic: VCready gates only new packets, never a locked one.
  always_comb begin
    req_ready = '0;
    unique case (state_q)
      NOC_ARB_IDLE: begin
        if (slot_free && Noc_sender_VCready && pick_any) begin
          req_ready = pick_gnt;
        end
      end
      NOC_ARB_LOCKED: begin
        if (slot_free) begin
          req_ready[grant_id_q] = 1'b1;
        end
      end
      default: req_ready = '0;
    endcase
  end

  assign Noc_sender_valid     = out_valid_q;
  assign Noc_sender_flit      = out_flit_q;
  assign Noc_sender_is_header = out_hdr_q;
  assign Noc_sender_is_tail   = out_tail_q;
  assign grant_id             = grant_id_q;
  assign busy                 = (state_q == NOC_ARB_LOCKED);
  assign err_proto            = err_q;
  assign pkt_count            = pkt_count_q;

  a_ready_onehot: assert property (@(posedge noc_clk) disable iff (noc_rst)
    $onehot0(req_ready));
  a_ready_needs_slot: assert property (@(posedge noc_clk) disable iff (noc_rst)
    (req_ready != '0) |-> slot_free);
  a_hold_stable: assert property (@(posedge noc_clk) disable iff (noc_rst)
    (Noc_sender_valid && !Noc_sender_ready) |=>
      (Noc_sender_valid && $stable(Noc_sender_flit) &&
       $stable(Noc_sender_is_header) && $stable(Noc_sender_is_tail)));

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed bench for noc_inject_arbiter: per-requester flit sources, a sink
// log of sender handshakes and hand-computed expectations per scenario.
module tb_noc_inject_arbiter;
  import noc_inject_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int DW = NOC_DATA_WIDTH;
  localparam int CW = 16;

  typedef struct {
    logic [DW-1:0] data;
    logic          hdr;
    logic          tail;
  } bflit_t;

  logic            noc_clk = 1'b0;
  logic            noc_rst;
  logic [NR-1:0]   req_valid, req_ready, req_is_header, req_is_tail;
  logic [NR*DW-1:0] req_flit;
  logic            snd_valid, snd_ready, snd_vc, snd_hdr, snd_tail;
  logic [DW-1:0]   snd_flit;
  logic [1:0]      grant_id;
  logic            busy, err_proto;
  logic [CW-1:0]   pkt_count;

  int              n_cmp = 0;
  int              n_bad = 0;
  bflit_t          src_q [NR][$];
  bflit_t          sink_q[$];
  logic [NR-1:0]   last_rdy;

  noc_inject_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .noc_clk              (noc_clk),
    .noc_rst              (noc_rst),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_flit             (req_flit),
    .req_is_header        (req_is_header),
    .req_is_tail          (req_is_tail),
    .Noc_sender_valid     (snd_valid),
    .Noc_sender_ready     (snd_ready),
    .Noc_sender_flit      (snd_flit),
    .Noc_sender_VCready   (snd_vc),
    .Noc_sender_is_header (snd_hdr),
    .Noc_sender_is_tail   (snd_tail),
    .grant_id             (grant_id),
    .busy                 (busy),
    .err_proto            (err_proto),
    .pkt_count            (pkt_count)
  );

  always #5 noc_clk = ~noc_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic bflit_t mk(input logic [DW-1:0] d, input logic h, input logic t);
    bflit_t f;
    f.data = d;
    f.hdr  = h;
    f.tail = t;
    return f;
  endfunction

  function automatic bit pending();
    bit p = snd_valid;
    for (int r = 0; r < NR; r++) if (src_q[r].size() != 0) p = 1'b1;
    return p;
  endfunction

  // One clock: drive sources, sample ready and sender handshake, advance.
  task automatic tick();
    bit     hs;
    bflit_t sf;
    for (int r = 0; r < NR; r++) begin
      if (src_q[r].size() != 0) begin
        req_valid[r]             = 1'b1;
        req_flit[r*DW +: DW]     = src_q[r][0].data;
        req_is_header[r]         = src_q[r][0].hdr;
        req_is_tail[r]           = src_q[r][0].tail;
      end else begin
        req_valid[r]             = 1'b0;
        req_flit[r*DW +: DW]     = '0;
        req_is_header[r]         = 1'b0;
        req_is_tail[r]           = 1'b0;
      end
    end
    #1;
    last_rdy = req_ready;
    hs       = snd_valid && snd_ready;
    sf       = mk(snd_flit, snd_hdr, snd_tail);
    @(posedge noc_clk);
    #1;
    for (int r = 0; r < NR; r++) if (last_rdy[r] && req_valid[r]) void'(src_q[r].pop_front());
    if (hs) sink_q.push_back(sf);
  endtask

  task automatic drain(output bit ok);
    int n = 0;
    while (pending() && n < 60) begin
      tick();
      n++;
    end
    ok = !pending();
  endtask

  task automatic apply_reset();
    noc_rst   = 1'b1;
    snd_ready = 1'b1;
    snd_vc    = 1'b1;
    for (int r = 0; r < NR; r++) src_q[r].delete();
    tick();
    tick();
    noc_rst = 1'b0;
    sink_q.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (snd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0h want 0", snd_valid); end
    n_cmp++; if (snd_flit !== '0) begin n_bad++; $display("FAIL rst_flit: got %0h want 0", snd_flit); end
    n_cmp++; if ({snd_hdr, snd_tail, busy, err_proto} !== 4'b0) begin n_bad++; $display("FAIL rst_flags: got %b want 0000", {snd_hdr, snd_tail, busy, err_proto}); end
    n_cmp++; if (grant_id !== 2'd0 || pkt_count !== '0) begin n_bad++; $display("FAIL rst_gid_cnt: got %0d/%0d want 0/0", grant_id, pkt_count); end
    n_cmp++; if (dut.rr_ptr_q !== 2'd0 || dut.state_q !== NOC_ARB_IDLE) begin n_bad++; $display("FAIL rst_ptr_state: got %0d/%0d want 0/IDLE", dut.rr_ptr_q, dut.state_q); end
  endtask

  task automatic test_single();
    logic [DW-1:0] exp_d [3];
    int busy_cycles = 0;
    exp_d = '{32'hA1, 32'hA2, 32'hA3};
    apply_reset();
    src_q[0].push_back(mk(32'hA1, 1'b1, 1'b0));
    src_q[0].push_back(mk(32'hA2, 1'b0, 1'b0));
    src_q[0].push_back(mk(32'hA3, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++) begin
      tick();
      busy_cycles += int'(busy);
      n_cmp++; if (last_rdy !== 4'b0001) begin n_bad++; $display("FAIL single_rdy[%0d]: got %b want 0001", i, last_rdy); end
      n_cmp++; if ({snd_valid, snd_flit, snd_hdr, snd_tail} !== {1'b1, exp_d[i], i == 0, i == 2}) begin
        n_bad++; $display("FAIL single_out[%0d]: got v%0b %0h h%0b t%0b want %0h", i, snd_valid, snd_flit, snd_hdr, snd_tail, exp_d[i]);
      end
    end
    n_cmp++; if (dut.rr_ptr_q !== 2'd1 || dut.state_q !== NOC_ARB_IDLE) begin n_bad++; $display("FAIL single_ptr: got %0d/%0d want 1/IDLE", dut.rr_ptr_q, dut.state_q); end
    tick();
    busy_cycles += int'(busy);
    n_cmp++; if (pkt_count !== 16'd1 || snd_valid !== 1'b0) begin n_bad++; $display("FAIL single_cnt: got %0d v%0b want 1 v0", pkt_count, snd_valid); end
    n_cmp++; if (busy_cycles != 2) begin n_bad++; $display("FAIL single_busy: got %0d want 2", busy_cycles); end
    n_cmp++; if (sink_q.size() != 3) begin n_bad++; $display("FAIL single_sink: got %0d want 3", sink_q.size()); end
  endtask

  task automatic test_fairness();
    logic [DW-1:0] exp_d [10];
    int exp_g [5];
    int gids[$];
    int n = 0;
    exp_d = '{32'h00, 32'h01, 32'h10, 32'h11, 32'h20, 32'h21, 32'h30, 32'h31, 32'h02, 32'h03};
    exp_g = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int r = 0; r < NR; r++) begin
      src_q[r].push_back(mk(DW'(r * 16), 1'b1, 1'b0));
      src_q[r].push_back(mk(DW'(r * 16 + 1), 1'b0, 1'b1));
    end
    src_q[0].push_back(mk(32'h02, 1'b1, 1'b0));
    src_q[0].push_back(mk(32'h03, 1'b0, 1'b1));
    while (pending() && n < 60) begin
      tick();
      n++;
      if (snd_valid && snd_hdr) gids.push_back(int'(grant_id));
    end
    n_cmp++; if (gids.size() != 5) begin n_bad++; $display("FAIL fair_ngrants: got %0d want 5", gids.size()); end
    for (int i = 0; i < 5 && i < gids.size(); i++) begin
      n_cmp++; if (gids[i] != exp_g[i]) begin n_bad++; $display("FAIL fair_gid[%0d]: got %0d want %0d", i, gids[i], exp_g[i]); end
    end
    n_cmp++; if (sink_q.size() != 10) begin n_bad++; $display("FAIL fair_nflits: got %0d want 10", sink_q.size()); end
    for (int i = 0; i < 10 && i < sink_q.size(); i++) begin
      n_cmp++; if (sink_q[i].data !== exp_d[i] || sink_q[i].hdr !== (i % 2 == 0)) begin
        n_bad++; $display("FAIL fair_flit[%0d]: got %0h h%0b want %0h", i, sink_q[i].data, sink_q[i].hdr, exp_d[i]);
      end
    end
    n_cmp++; if (err_proto !== 1'b0 || pkt_count !== 16'd5) begin n_bad++; $display("FAIL fair_end: got err%0b cnt %0d want err0 cnt 5", err_proto, pkt_count); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_d [4];
    bit ok;
    exp_d = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
    apply_reset();
    src_q[1].push_back(mk(32'hB0, 1'b1, 1'b0));
    src_q[1].push_back(mk(32'hB1, 1'b0, 1'b0));
    src_q[1].push_back(mk(32'hB2, 1'b0, 1'b0));
    src_q[1].push_back(mk(32'hB3, 1'b0, 1'b1));
    tick();
    tick();
    snd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (last_rdy !== 4'b0000) begin n_bad++; $display("FAIL bp_rdy[%0d]: got %b want 0000", i, last_rdy); end
      n_cmp++; if (snd_valid !== 1'b1 || snd_flit !== 32'hB1) begin n_bad++; $display("FAIL bp_hold[%0d]: got v%0b %0h want v1 b1", i, snd_valid, snd_flit); end
    end
    snd_ready = 1'b1;
    drain(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_drain: got stuck want drained"); end
    n_cmp++; if (sink_q.size() != 4) begin n_bad++; $display("FAIL bp_nflits: got %0d want 4", sink_q.size()); end
    for (int i = 0; i < 4 && i < sink_q.size(); i++) begin
      n_cmp++; if (sink_q[i].data !== exp_d[i]) begin n_bad++; $display("FAIL bp_flit[%0d]: got %0h want %0h", i, sink_q[i].data, exp_d[i]); end
    end
    n_cmp++; if (pkt_count !== 16'd1) begin n_bad++; $display("FAIL bp_cnt: got %0d want 1", pkt_count); end
  endtask

  task automatic test_vc_gating();
    bit ok;
    apply_reset();
    snd_vc = 1'b0;
    src_q[2].push_back(mk(32'hC0, 1'b1, 1'b0));
    src_q[2].push_back(mk(32'hC1, 1'b0, 1'b0));
    src_q[2].push_back(mk(32'hC2, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (last_rdy !== 4'b0000 || snd_valid !== 1'b0) begin n_bad++; $display("FAIL vc_gate[%0d]: got rdy %b v%0b want 0000 v0", i, last_rdy, snd_valid); end
    end
    snd_vc = 1'b1;
    tick();
    n_cmp++; if (last_rdy !== 4'b0100) begin n_bad++; $display("FAIL vc_grant: got %b want 0100", last_rdy); end
    n_cmp++; if (snd_flit !== 32'hC0 || snd_hdr !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL vc_hdr: got %0h h%0b busy%0b want c0 h1 busy1", snd_flit, snd_hdr, busy); end
    snd_vc = 1'b0;
    tick();
    n_cmp++; if (last_rdy !== 4'b0100 || snd_flit !== 32'hC1) begin n_bad++; $display("FAIL vc_mid: got %b %0h want 0100 c1", last_rdy, snd_flit); end
    tick();
    n_cmp++; if (snd_flit !== 32'hC2 || snd_tail !== 1'b1) begin n_bad++; $display("FAIL vc_tail: got %0h t%0b want c2 t1", snd_flit, snd_tail); end
    snd_vc = 1'b1;
    drain(ok);
    n_cmp++; if (!ok || sink_q.size() != 3 || pkt_count !== 16'd1) begin n_bad++; $display("FAIL vc_end: got ok%0b n%0d cnt %0d want 1 3 1", ok, sink_q.size(), pkt_count); end
  endtask

  task automatic test_single_flit_err();
    apply_reset();
    src_q[1].push_back(mk(32'h55, 1'b1, 1'b1));
    tick();
    n_cmp++; if (last_rdy !== 4'b0010) begin n_bad++; $display("FAIL sf_rdy: got %b want 0010", last_rdy); end
    n_cmp++; if ({snd_valid, snd_flit, snd_hdr, snd_tail} !== {1'b1, 32'h55, 1'b1, 1'b1}) begin n_bad++; $display("FAIL sf_out: got %0h h%0b t%0b want 55 h1 t1", snd_flit, snd_hdr, snd_tail); end
    n_cmp++; if (dut.state_q !== NOC_ARB_IDLE || busy !== 1'b0 || dut.rr_ptr_q !== 2'd2) begin n_bad++; $display("FAIL sf_state: got %0d busy%0b ptr %0d want IDLE 0 2", dut.state_q, busy, dut.rr_ptr_q); end
    tick();
    n_cmp++; if (pkt_count !== 16'd1 || err_proto !== 1'b0) begin n_bad++; $display("FAIL sf_cnt: got %0d err%0b want 1 err0", pkt_count, err_proto); end
    src_q[3].push_back(mk(32'h77, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (last_rdy !== 4'b0000 || snd_valid !== 1'b0) begin n_bad++; $display("FAIL err_rdy[%0d]: got %b v%0b want 0000 v0", i, last_rdy, snd_valid); end
      n_cmp++; if (err_proto !== 1'b1) begin n_bad++; $display("FAIL err_flag[%0d]: got %0b want 1", i, err_proto); end
    end
    src_q[3].delete();
    tick();
    n_cmp++; if (err_proto !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %0b want 1", err_proto); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    src_q[2].push_back(mk(32'h66, 1'b1, 1'b1));
    tick();
    tick();
    n_cmp++; if (pkt_count !== 16'd1 || dut.rr_ptr_q !== 2'd3) begin n_bad++; $display("FAIL rm_pre: got cnt %0d ptr %0d want 1 3", pkt_count, dut.rr_ptr_q); end
    src_q[0].push_back(mk(32'hD0, 1'b1, 1'b0));
    src_q[0].push_back(mk(32'hD1, 1'b0, 1'b0));
    src_q[0].push_back(mk(32'hD2, 1'b0, 1'b0));
    src_q[0].push_back(mk(32'hD3, 1'b0, 1'b1));
    tick();
    tick();
    n_cmp++; if (busy !== 1'b1 || snd_flit !== 32'hD1 || grant_id !== 2'd0) begin n_bad++; $display("FAIL rm_mid: got busy%0b %0h g%0d want 1 d1 0", busy, snd_flit, grant_id); end
    noc_rst = 1'b1;
    for (int r = 0; r < NR; r++) src_q[r].delete();
    tick();
    noc_rst = 1'b0;
    n_cmp++; if ({snd_valid, snd_flit, snd_hdr, snd_tail} !== '0) begin n_bad++; $display("FAIL rm_out: got v%0b %0h h%0b t%0b want all 0", snd_valid, snd_flit, snd_hdr, snd_tail); end
    n_cmp++; if (busy !== 1'b0 || grant_id !== 2'd0 || pkt_count !== '0 || err_proto !== 1'b0) begin n_bad++; $display("FAIL rm_regs: got busy%0b g%0d cnt %0d err%0b want 0", busy, grant_id, pkt_count, err_proto); end
    n_cmp++; if (dut.state_q !== NOC_ARB_IDLE || dut.rr_ptr_q !== 2'd0) begin n_bad++; $display("FAIL rm_fsm: got %0d ptr %0d want IDLE 0", dut.state_q, dut.rr_ptr_q); end
    sink_q.delete();
    src_q[1].push_back(mk(32'hE0, 1'b1, 1'b0));
    src_q[1].push_back(mk(32'hE1, 1'b0, 1'b1));
    tick();
    n_cmp++; if (last_rdy !== 4'b0010 || snd_flit !== 32'hE0 || snd_hdr !== 1'b1 || grant_id !== 2'd1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL rm_regrant: got rdy %b %0h h%0b g%0d busy%0b want 0010 e0 1 1 1", last_rdy, snd_flit, snd_hdr, grant_id, busy);
    end
    drain(ok);
    n_cmp++; if (!ok || sink_q.size() != 2 || pkt_count !== 16'd1) begin n_bad++; $display("FAIL rm_end: got ok%0b n%0d cnt %0d want 1 2 1", ok, sink_q.size(), pkt_count); end
  endtask

  initial begin
    noc_rst       = 1'b1;
    snd_ready     = 1'b1;
    snd_vc        = 1'b1;
    req_valid     = '0;
    req_flit      = '0;
    req_is_header = '0;
    req_is_tail   = '0;
    last_rdy      = '0;
    @(posedge noc_clk);
    #1;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_vc_gating();
    test_single_flit_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/noc_inject_arbiter.md
Name: noc_inject_arbiter

Overview:
- Packet-level wormhole arbiter that shares one NoC router injection port among NUM_REQ local packet sources, such as PE DMA, config master and debug.
- Sits between the local requesters and a node's Noc_X_Y_receive_* port, the input of the per-node bridge.
- Locks the port for a whole packet (header to tail) and enforces round-robin fairness between packets.
- Gates new packets on the router's VCready and registers the output flit stage.

Parameters:
- NUM_REQ, 4, number of local requesters (2..8).
- DATA_WIDTH, `Noc_Data_Width, flit width in bits.
- CNT_WIDTH, 16, width of the delivered-packet counter.

Ports:
- noc_clk  in  1  sole clock.
- noc_rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester flit valid.
- req_ready  out  NUM_REQ  per-requester flit accept.
- req_flit  in  NUM_REQ*DATA_WIDTH  packed flits; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_is_header  in  NUM_REQ  flit is packet header.
- req_is_tail  in  NUM_REQ  flit is packet tail; header and tail both 1 means a single-flit packet.
- Noc_sender_valid  out  1  flit valid toward router.
- Noc_sender_ready  in  1  router accepts flit.
- Noc_sender_flit  out  DATA_WIDTH  flit.
- Noc_sender_VCready  in  1  router has a free VC for a new packet.
- Noc_sender_is_header  out  1  header marker.
- Noc_sender_is_tail  out  1  tail marker.
- grant_id  out  clog2(NUM_REQ)  current or last granted requester.
- busy  out  1  1 while in LOCKED state.
- err_proto  out  1  sticky protocol-error flag; cleared only by reset.
- pkt_count  out  CNT_WIDTH  packets delivered (tail handshakes on the sender port).

Behaviour:
- Interface fixed: one clock noc_clk; reset noc_rst is synchronous and active-high.
- Reset values:
  - Noc_sender_valid/flit/is_header/is_tail = 0.
  - busy = 0, grant_id = 0, rr_ptr = 0, err_proto = 0, pkt_count = 0.
  - State = IDLE.
- Reset mid-packet: the packet is abandoned with no tail emitted. Upstream and router are reset by the same noc_rst.
- Output stage:
  - One register slot; slot_free = !Noc_sender_valid | Noc_sender_ready.
  - A flit accepted from a requester in cycle t drives Noc_sender_* in t+1. Throughput is 1 flit/cycle.
  - Noc_sender_* are held stable while valid=1 and ready=0.
- req_ready is combinational. At most one bit is set; it is never set when slot_free=0.
- IDLE state:
  - Candidates: requesters with req_valid=1 and req_is_header=1.
  - A grant happens only if slot_free=1 and Noc_sender_VCready=1.
  - Winner: first candidate at or after rr_ptr, searching cyclically.
  - On grant: req_ready[winner]=1, the header is loaded into the slot, grant_id=winner.
  - If the header is not also a tail: go to LOCKED.
  - If header and tail are both 1: stay IDLE and set rr_ptr=winner+1 mod NUM_REQ.
  - A valid non-header flit in IDLE is never accepted (ready=0) and sets err_proto.
- LOCKED state:
  - req_ready[grant_id]=slot_free; all other bits are 0.
  - VCready is ignored mid-packet.
  - On an accepted flit with is_tail=1: go to IDLE and set rr_ptr=grant_id+1 mod NUM_REQ.
  - On an accepted flit with is_header=1: set err_proto; the flit is still forwarded as-is and the lock is kept.
- Simultaneous events:
  - A tail accept in LOCKED and a new header do not share a cycle. The next grant earliest follows in the cycle after the tail is accepted.
  - Output drain and a new load in the same cycle are allowed.
- pkt_count:
  - Increments when Noc_sender_valid & Noc_sender_ready & Noc_sender_is_tail.
  - Wraps from 2^CNT_WIDTH-1 to 0.

Decomposition:
- Shared Noc package / Noc_parameters.v: `Noc_Data_Width`, plus new constants NOC_ARB_IDLE and NOC_ARB_LOCKED.
- One sub-module: noc_rr_picker, a combinational round-robin first-set finder. Inputs are the request vector and rr_ptr; outputs are a one-hot grant and its index. It is reusable by the bridge's channel scheduler.

Test Plan:
- Single requester (NUM_REQ=4): req0 sends a 3-flit packet 0xA1(H), 0xA2, 0xA3(T) with ready held 1. Required response:
  - Flits appear on the sender one cycle later, consecutively.
  - busy is 1 for 2 cycles; pkt_count=1; rr_ptr=1.
- Fairness: req0..req3 all hold 2-flit packets continuously from rr_ptr=0 → packet order is 0,1,2,3,0.
  - No interleaving of flits between packets.
  - grant_id tracks 0,1,2,3,0.
- Backpressure: Noc_sender_ready=0 for 5 cycles mid-packet. Required response:
  - Sender flit is held stable and req_ready[g]=0 throughout.
  - After release, there is no flit loss or duplication.
- VC gating: Noc_sender_VCready=0 while req2 has a header pending → no grant.
  - VCready→1 → grant in that cycle, header out next cycle.
  - VCready dropping mid-packet does not stall the packet.
- Single-flit packets and errors:
  - req1 sends H+T 0x55 → state stays IDLE and pkt_count increments.
  - req3 sends a body flit with no header → never accepted and err_proto=1.
- Reset mid-packet: assert noc_rst during flit 2 of 4 → next cycle all outputs are 0, state IDLE, rr_ptr=0, pkt_count=0.
  - A fresh header is granted normally after reset.
